// File: rtl/decode_queue_mw.sv
// Multi-issue decode queue: a fetch group of SLOT_N micro-op slots comes in, NOP slots
// are dropped, survivors are compacted into a circular buffer, and up to ISSUE_N of the
// oldest entries are presented to issue with a take-count handshake.
module decode_queue_mw #(
  parameter int unsigned      SLOT_N   = 4,
  parameter int unsigned      DEPTH    = 8,
  parameter int unsigned      ISSUE_N  = 2,
  parameter int unsigned      UOP_W    = 96,
  parameter int unsigned      OPC_W    = 8,
  parameter logic [OPC_W-1:0] NOP_CODE = '0
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             flush,
  input  logic [SLOT_N*UOP_W-1:0]          fet_group,
  input  logic                             fet_inst_valid,
  output logic                             fet_ready,
  output logic [ISSUE_N*UOP_W-1:0]         deq_uop,
  output logic [ISSUE_N-1:0]               deq_valid,
  input  logic [$clog2(ISSUE_N+1)-1:0]     deq_take,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             empty,
  output logic                             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OFF_W = $clog2(SLOT_N + 1);
  localparam int unsigned OPC_LSB = UOP_W - OPC_W;

  logic [UOP_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] eff_take;
  logic [SLOT_N-1:0] slot_valid;
  logic [PTR_W-1:0]  wr_idx [SLOT_N];
  logic [OFF_W-1:0]  n_enq;
  logic              enq_fire;

  // Slot decode: validity per slot and compacted write index (tail + valid slots before it)
  always_comb begin
    n_enq = '0;
    for (int unsigned k = 0; k < SLOT_N; k++) begin
      slot_valid[k] = fet_group[k*UOP_W + OPC_LSB +: OPC_W] != NOP_CODE;
      wr_idx[k]     = tail_q + PTR_W'(n_enq);
      n_enq         = n_enq + OFF_W'(slot_valid[k]);
    end
  end

  // Ready depends only on registered occupancy, never on this cycle's dequeue
  assign fet_ready = count_q <= CNT_W'(DEPTH - SLOT_N);
  assign enq_fire  = fet_inst_valid & fet_ready & ~flush;

  // Clip the requested take to the lane count and to live entries
  always_comb begin
    eff_take = CNT_W'(deq_take);
    if (eff_take > CNT_W'(ISSUE_N)) eff_take = CNT_W'(ISSUE_N);
    if (eff_take > count_q)         eff_take = count_q;
  end

  // Next-state pointers and occupancy; flush overrides both enqueue and dequeue
  always_comb begin
    head_d  = head_q + PTR_W'(eff_take);
    tail_d  = tail_q;
    count_d = count_q - eff_take;
    if (enq_fire) begin
      tail_d  = tail_q + PTR_W'(n_enq);
      count_d = count_d + CNT_W'(n_enq);
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write; the array is deliberately left unreset, liveness comes from count_q
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int unsigned k = 0; k < SLOT_N; k++) begin
        if (slot_valid[k]) mem_q[wr_idx[k]] <= fet_group[k*UOP_W +: UOP_W];
      end
    end
  end

  // Head lanes straight from registers; dead lanes show a clean NOP
  always_comb begin
    logic [PTR_W-1:0] rd_idx;
    deq_uop   = '0;
    deq_valid = '0;
    for (int unsigned i = 0; i < ISSUE_N; i++) begin
      rd_idx = head_q + PTR_W'(i);
      if (count_q > CNT_W'(i)) begin
        deq_valid[i]                = 1'b1;
        deq_uop[i*UOP_W +: UOP_W]   = mem_q[rd_idx];
      end else begin
        deq_uop[i*UOP_W + OPC_LSB +: OPC_W] = NOP_CODE;
      end
    end
  end

  assign count = count_q;
  assign empty = count_q == '0;
  assign full  = count_q == CNT_W'(DEPTH);

  a_count_bound: assert property (@(posedge clk) disable iff (!rstn)
    count_q <= CNT_W'(DEPTH));
  a_ptr_count: assert property (@(posedge clk) disable iff (!rstn)
    PTR_W'(tail_q - head_q) == PTR_W'(count_q));
  a_full_not_ready: assert property (@(posedge clk) disable iff (!rstn)
    full |-> !fet_ready);

endmodule

// File: tb/tb_decode_queue_mw.sv
// Bench for decode_queue_mw: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the micro-op stream.
module tb_decode_queue_mw;

  localparam int SLOT_N  = 4;
  localparam int DEPTH   = 8;
  localparam int ISSUE_N = 2;
  localparam int UOP_W   = 96;
  localparam int OPC_W   = 8;

  logic                      clk = 1'b0;
  logic                      rstn = 1'b0;
  logic                      flush = 1'b0;
  logic [SLOT_N*UOP_W-1:0]   fet_group = '0;
  logic                      fet_inst_valid = 1'b0;
  logic                      fet_ready;
  logic [ISSUE_N*UOP_W-1:0]  deq_uop;
  logic [ISSUE_N-1:0]        deq_valid;
  logic [1:0]                deq_take = '0;
  logic [3:0]                count;
  logic                      empty;
  logic                      full;

  int tests = 0;
  int fails = 0;

  // Reference: the live entries in age order
  logic [UOP_W-1:0] mq[$];
  logic [7:0]       got[$];

  always #5 clk = ~clk;

  decode_queue_mw #(
    .SLOT_N  (SLOT_N),
    .DEPTH   (DEPTH),
    .ISSUE_N (ISSUE_N),
    .UOP_W   (UOP_W),
    .OPC_W   (OPC_W),
    .NOP_CODE(8'h00)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .flush         (flush),
    .fet_group     (fet_group),
    .fet_inst_valid(fet_inst_valid),
    .fet_ready     (fet_ready),
    .deq_uop       (deq_uop),
    .deq_valid     (deq_valid),
    .deq_take      (deq_take),
    .count         (count),
    .empty         (empty),
    .full          (full)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] mk(input logic [7:0] op);
    return {op, 24'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [383:0] grp(input logic [7:0] o0, input logic [7:0] o1,
                                       input logic [7:0] o2, input logic [7:0] o3);
    return {mk(o3), mk(o2), mk(o1), mk(o0)};
  endfunction

  task automatic check_outputs();
    int n;
    n = mq.size();
    chk("count", 96'(count), 96'(n));
    chk("empty", 96'(empty), 96'(n == 0));
    chk("full", 96'(full), 96'(n == DEPTH));
    chk("fet_ready", 96'(fet_ready), 96'((DEPTH - n) >= SLOT_N));
    for (int i = 0; i < ISSUE_N; i++) begin
      chk($sformatf("deq_valid%0d", i), 96'(deq_valid[i]), 96'(n > i));
      chk($sformatf("deq_uop%0d", i), deq_uop[i*UOP_W +: UOP_W], (n > i) ? mq[i] : 96'h0);
    end
  endtask

  // Model of one clock edge, using pre-edge occupancy for readiness
  task automatic model_step(input logic [383:0] g, input bit v, input int t, input bit f);
    int n;
    int eff;
    bit rdy;
    if (f) begin
      mq.delete();
    end else begin
      n   = mq.size();
      rdy = (DEPTH - n) >= SLOT_N;
      eff = t;
      if (eff > ISSUE_N) eff = ISSUE_N;
      if (eff > n) eff = n;
      repeat (eff) void'(mq.pop_front());
      if (v && rdy) begin
        for (int k = 0; k < SLOT_N; k++)
          if (g[k*UOP_W + 88 +: 8] != 8'h00) mq.push_back(g[k*UOP_W +: UOP_W]);
      end
    end
  endtask

  task automatic cycle(input logic [383:0] g, input bit v, input int t, input bit f);
    fet_group      = g;
    fet_inst_valid = v;
    deq_take       = 2'(t);
    flush          = f;
    @(posedge clk);
    model_step(g, v, t, f);
    #1;
    check_outputs();
    fet_inst_valid = 1'b0;
    deq_take       = '0;
    flush          = 1'b0;
  endtask

  initial begin
    int nxt;
    int cyc;
    int n;
    int eff;
    logic [7:0] o [4];

    // Reset state
    #12;
    check_outputs();
    @(negedge clk);
    rstn = 1'b1;

    // Group with a NOP hole compacts to A,B,C
    cycle(grp(8'hA1, 8'h00, 8'hB2, 8'hC3), 1, 0, 0);
    chk("tp1_count", 96'(count), 96'd3);
    chk("tp1_lane0", 96'(deq_uop[95:88]), 96'hA1);
    chk("tp1_lane1", 96'(deq_uop[191:184]), 96'hB2);
    chk("tp1_valid", 96'(deq_valid), 96'b11);
    chk("tp1_ready", 96'(fet_ready), 96'd1);

    // Fill to full, then an offered group is dropped
    cycle('0, 0, 0, 1);
    cycle(grp(1, 2, 3, 4), 1, 0, 0);
    cycle(grp(5, 6, 7, 8), 1, 0, 0);
    chk("tp2_full", 96'(full), 96'd1);
    chk("tp2_ready", 96'(fet_ready), 96'd0);
    cycle(grp(9, 10, 11, 12), 1, 0, 0);
    chk("tp2_count", 96'(count), 96'd8);
    chk("tp2_lane0", 96'(deq_uop[95:88]), 96'd1);

    // Drain to 3, then simultaneous take-2 and enqueue of two
    cycle('0, 0, 2, 0);
    cycle('0, 0, 2, 0);
    cycle('0, 0, 1, 0);
    cycle(grp(9, 0, 0, 8'h0A), 1, 2, 0);
    chk("tp3_count", 96'(count), 96'd3);
    chk("tp3_lane0", 96'(deq_uop[95:88]), 96'd8);
    chk("tp3_lane1", 96'(deq_uop[191:184]), 96'd9);
    cycle('0, 0, 2, 0);
    chk("tp3_tail", 96'(deq_uop[95:88]), 96'h0A);

    // Over-take from a single entry clips without underflow
    cycle('0, 0, 2, 0);
    chk("tp5_count", 96'(count), 96'd0);
    chk("tp5_empty", 96'(empty), 96'd1);
    chk("tp5_lane0", 96'(deq_uop[95:88]), 96'd0);

    // Flush wins over a same-cycle enqueue and dequeue
    cycle(grp(1, 2, 3, 4), 1, 0, 0);
    cycle(grp(5, 0, 0, 0), 1, 0, 0);
    chk("tp6_pre", 96'(count), 96'd5);
    cycle(grp(6, 7, 8, 9), 1, 1, 1);
    chk("tp6_count", 96'(count), 96'd0);

    // Streaming 1..40 with take=2 every cycle, wrapping the pointers
    nxt = 1;
    cyc = 0;
    while (got.size() < 40 && cyc < 200) begin
      n   = mq.size();
      eff = (n < 2) ? n : 2;
      for (int i = 0; i < eff; i++) got.push_back(deq_uop[i*UOP_W + 88 +: 8]);
      if (nxt <= 40 && (DEPTH - n) >= SLOT_N) begin
        cycle(grp(8'(nxt), 8'(nxt + 1), 8'(nxt + 2), 8'(nxt + 3)), 1, 2, 0);
        nxt += 4;
      end else begin
        cycle('0, 0, 2, 0);
      end
      cyc++;
    end
    chk("stream_len", 96'(got.size()), 96'd40);
    for (int i = 0; i < got.size(); i++) chk($sformatf("stream%0d", i), 96'(got[i]), 96'(i + 1));

    // Asynchronous reset mid-stream acts before the next edge
    cycle(grp(1, 2, 3, 4), 1, 0, 0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("arst_valid", 96'(deq_valid), 96'd0);
    chk("arst_empty", 96'(empty), 96'd1);
    chk("arst_count", 96'(count), 96'd0);
    mq.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++)
        o[k] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      cycle(grp(o[0], o[1], o[2], o[3]), $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 3)), $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
